// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// A start pulse latches the op and operands. A down-counter then models the
// fixed latency, and the result is committed to HI/LO on the edge where busy
// falls. mthi/mtlo write HI/LO directly while the unit is idle.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_t;

    // Handshake: start is a one-cycle request. It is accepted only when
    // busy=0 and md_op names a mult/div. A request made while busy is
    // dropped, not queued, because the D-stage stall on (start || busy)
    // guarantees that a legal program never issues one. busy is derived from
    // registered state only.

    md_op_t      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  cnt;

    logic        is_md_start;
    logic        is_div_start;
    logic        signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    assign busy         = (cnt != 4'd0);
    assign is_md_start  = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                          (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign is_div_start = (md_op == OP_DIV) || (md_op == OP_DIVU);

    // Result datapath from the latched operands. Signed division runs on
    // magnitudes, so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    always_comb begin
        signed_div = (op_q == OP_DIV);
        a_mag      = a_q;
        b_mag      = b_q;
        if (signed_div && a_q[31]) a_mag = ~a_q + 32'd1;
        if (signed_div && b_q[31]) b_mag = ~b_q + 32'd1;
        div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / div_den;
        r_mag   = a_mag % div_den;
        quot    = (signed_div && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
        rem     = (signed_div && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
        prod    = 64'd0;
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_wr  = 1'b0;
        case (op_q)
            OP_MULT: begin
                prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                prod   = {32'd0, a_q} * {32'd0, b_q};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // A zero divisor keeps HI/LO unchanged at commit.
                res_hi = rem;
                res_lo = quot;
                res_wr = (b_q != 32'd0);
            end
            default: begin
                res_wr = 1'b0;
            end
        endcase
    end

    // Latency counter and latched operation: load on an accepted start, count down while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= 4'd0;
            op_q <= OP_NONE;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
        end else if (start && is_md_start) begin
            op_q <= md_op_t'(md_op);
            a_q  <= A;
            b_q  <= B;
            cnt  <= is_div_start ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
    end

    // HI/LO: commit the result on the last busy edge, or take a direct mthi/mtlo write when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (busy) begin
            if ((cnt == 4'd1) && res_wr) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end else if (!start && (md_op == OP_MTHI)) begin
            HI <= A;
        end else if (!start && (md_op == OP_MTLO)) begin
            LO <= A;
        end
    end

endmodule
